// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the registered N-way selector.
// Optional error counter is enabled with MUX_PIPE_SEL_ERR_CNT_EN.
package mux_pipe_pkg;

  localparam int MAX_N     = 16;
  localparam int ERR_CNT_W = 16;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_slot.sv
// Single holding register: data, valid and err with load/clear.
// Load wins over clear; clear drops valid and err but keeps data.
module mux_pipe_slot
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             err_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             err;
  } slot_t;

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d.data  = data_i;
      slot_d.valid = 1'b1;
      slot_d.err   = err_i;
    end else if (clr_i) begin
      slot_d.valid = 1'b0;
      slot_d.err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign data_o  = slot_q.data;
  assign valid_o = slot_q.valid;
  assign err_o   = slot_q.err;

endmodule

// File: rtl/mux_pipe_sel.sv
// Registered N-way selector with 2-entry skid buffer, flush, sel_err.
// MUX_PIPE_SEL_ERR_CNT_EN adds err_cnt / err_cnt_clr.
module mux_pipe_sel
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
  input  logic                 err_cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

  logic [WIDTH-1:0] word;
  logic             word_err;

  always_comb begin
    word     = '0;
    word_err = ({1'b0, sel} >= N_L);
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        word = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  logic             m_load, m_clr, m_valid, m_err;
  logic             s_load, s_clr, s_valid, s_err;
  logic [WIDTH-1:0] m_data, s_data, m_data_d;
  logic             m_err_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = m_valid & out_ready;

  always_comb begin
    m_load     = 1'b0;
    m_clr      = 1'b0;
    s_load     = 1'b0;
    s_clr      = 1'b0;
    m_data_d   = word;
    m_err_d    = word_err;
    in_ready_d = in_ready_q;
    if (flush) begin
      m_clr      = 1'b1;
      s_clr      = 1'b1;
      in_ready_d = 1'b1;
    end else if (pop && s_valid) begin
      m_load     = 1'b1;
      m_data_d   = s_data;
      m_err_d    = s_err;
      s_clr      = 1'b1;
      in_ready_d = 1'b1;
    end else if (accept && (!m_valid || pop)) begin
      m_load = 1'b1;
    end else if (accept) begin
      // S is empty here because in_ready_q tracks !S.valid
      s_load     = 1'b1;
      in_ready_d = 1'b0;
    end else if (pop) begin
      m_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  mux_pipe_slot #(.WIDTH(WIDTH)) u_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .data_i  (m_data_d),
    .err_i   (m_err_d),
    .data_o  (m_data),
    .valid_o (m_valid),
    .err_o   (m_err)
  );

  mux_pipe_slot #(.WIDTH(WIDTH)) u_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (s_load),
    .clr_i   (s_clr),
    .data_i  (word),
    .err_i   (word_err),
    .data_o  (s_data),
    .valid_o (s_valid),
    .err_o   (s_err)
  );

  assign in_ready  = in_ready_q;
  assign data_out  = m_data;
  assign out_valid = m_valid;
  assign sel_err   = m_err;

`ifdef MUX_PIPE_SEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_cnt_clr) begin
      cnt_d = '0;
    end else if (accept && word_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Bench: N=4 and N=3 instances share stimulus; queue model checks both.
// Covers MUX_PIPE_SEL_ERR_CNT_EN when that macro is defined.
module tb_mux_pipe_sel;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] data_in;
  logic [1:0]   sel;
  logic         in_valid, out_ready, flush;
  logic         rdy4, rdy3, ov4, ov3, err4, err3;
  logic [31:0]  do4, do3;
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
  logic         err_cnt_clr;
  logic [15:0]  cnt4, cnt3;
`endif

  mux_pipe_sel #(.WIDTH(32), .N(4)) u4 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (cnt4),
`endif
    .data_in     (data_in),
    .sel         (sel),
    .in_valid    (in_valid),
    .in_ready    (rdy4),
    .flush       (flush),
    .data_out    (do4),
    .out_valid   (ov4),
    .out_ready   (out_ready),
    .sel_err     (err4)
  );

  mux_pipe_sel #(.WIDTH(32), .N(3)) u3 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (cnt3),
`endif
    .data_in     (data_in[95:0]),
    .sel         (sel),
    .in_valid    (in_valid),
    .in_ready    (rdy3),
    .flush       (flush),
    .data_out    (do3),
    .out_valid   (ov3),
    .out_ready   (out_ready),
    .sel_err     (err3)
  );

  typedef struct {
    logic [31:0] d4;
    logic        e4;
    logic [31:0] d3;
    logic        e3;
  } ent_t;

  ent_t        q[$];
  logic [31:0] hold4, hold3;
  int unsigned mcnt;
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold4 = '0;
    hold3 = '0;
    mcnt  = 0;
  endtask

  // Words form a FIFO of depth 2; data_out shows the head or the last head
  task automatic model_edge();
    ent_t e;
    bit   acc, pp;
    int   s;
    s    = int'(sel);
    acc  = in_valid && (q.size() < 2);
    pp   = (q.size() > 0) && out_ready;
    e.d4 = data_in[s*32 +: 32];
    e.e4 = 1'b0;
    e.e3 = (s >= 3);
    e.d3 = e.e3 ? 32'h0 : e.d4;
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
    if (err_cnt_clr) mcnt = 0;
    else if (acc && e.e3 && mcnt < 65535) mcnt++;
`endif
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) begin
      hold4 = q[0].d4;
      hold3 = q[0].d3;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready4", {31'b0, rdy4}, {31'b0, q.size() < 2});
      check("in_ready3", {31'b0, rdy3}, {31'b0, q.size() < 2});
      check("out_valid4", {31'b0, ov4}, {31'b0, q.size() > 0});
      check("out_valid3", {31'b0, ov3}, {31'b0, q.size() > 0});
      check("data_out4", do4, hold4);
      check("data_out3", do3, hold3);
      if (q.size() > 0) begin
        check("sel_err4", {31'b0, err4}, {31'b0, q[0].e4});
        check("sel_err3", {31'b0, err3}, {31'b0, q[0].e3});
      end
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
      check("err_cnt4", {16'b0, cnt4}, 32'h0);
      check("err_cnt3", {16'b0, cnt3}, mcnt);
`endif
    end
  end

  logic [31:0] exp_s[4];

  initial begin
    exp_s = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    sel       = '0;
    data_in   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, ov4}, 32'h0);
    check("rst_in_ready", {31'b0, rdy4}, 32'h1);
    check("rst_data_out", do4, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cyc();
      check("stream_data", do4, exp_s[i]);
      check("stream_ready", {31'b0, rdy4}, 32'h1);
    end
    in_valid = 1'b0;
    cyc();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    cyc();
    sel = 2'd2;
    cyc();
    in_valid = 1'b0;
    check("bp_m", do4, 32'hBBBB0001);
    check("bp_ready", {31'b0, rdy4}, 32'h0);
    out_ready = 1'b1;
    cyc();
    check("bp_s", do4, 32'hCCCC0002);
    check("bp_ready_up", {31'b0, rdy4}, 32'h1);
    cyc();
    check("bp_empty", {31'b0, ov4}, 32'h0);

    in_valid = 1'b1;
    sel      = 2'd3;
    cyc();
    check("oor_data3", do3, 32'h0);
    check("oor_err3", {31'b0, err3}, 32'h1);
    check("oor_valid3", {31'b0, ov3}, 32'h1);
    check("oor_data4", do4, 32'hDDDD0003);
    sel = 2'd0;
    cyc();
    check("oor_clear3", {31'b0, err3}, 32'h0);
    check("oor_next3", do3, 32'hAAAA0000);
    in_valid = 1'b0;
    cyc();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    cyc();
    cyc();
    check("fl_full", {31'b0, rdy3}, 32'h0);
    check("fl_err_pre", {31'b0, err3}, 32'h1);
    flush = 1'b1;
    sel   = 2'd0;
    cyc();
    flush = 1'b0;
    check("fl_valid", {31'b0, ov3}, 32'h0);
    check("fl_ready", {31'b0, rdy3}, 32'h1);
    check("fl_err", {31'b0, err3}, 32'h0);
    sel = 2'd1;
    cyc();
    flush = 1'b1;
    sel   = 2'd2;
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    check("fl_drop", {31'b0, ov4}, 32'h0);

    in_valid  = 1'b1;
    out_ready = 1'b0;
    sel       = 2'd2;
    cyc();
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_valid", {31'b0, ov4}, 32'h0);
    check("arst_ready", {31'b0, rdy4}, 32'h1);
    check("arst_data", do4, 32'h0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      data_in   = {$urandom, $urandom, $urandom, $urandom};
      sel       = 2'($urandom_range(3));
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(29) == 0);
`ifdef MUX_PIPE_SEL_ERR_CNT_EN
      err_cnt_clr = ($urandom_range(99) == 0);
`endif
      cyc();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
